// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and decoder state type for the PWM blocks
package pwm_pkg;
    localparam int PWM_PERIOD = 256;
    localparam int PWM_CNT_W  = $clog2(PWM_PERIOD) + 1;
    typedef enum logic {SEARCH, LOCKED} pwm_dec_state_t;
endpackage

// File: rtl/pwm_sync.sv
// pwm_sync: multi-flop synchronizer for an asynchronous level input, resets to 0
module pwm_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else sr <= {sr[SYNC_STAGES-2:0], d};
    end
    assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/pwm_left_decoder.sv
// pwm_left_decoder: measures high ticks per frame of a left-aligned PWM input,
// aligning frames on the frame-start rising edge
module pwm_left_decoder
    import pwm_pkg::*;
#(
    parameter int PERIOD      = PWM_PERIOD,
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty_cycle,
    output logic             valid,
    output logic             locked,
    output logic             sync_err
);
    localparam logic [CNT_W-1:0] PER      = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(PERIOD - 1);
    pwm_dec_state_t state, state_nxt;
    logic sample, prev, rise, boundary, run_done, publish, err;
    logic [CNT_W-1:0] tick_cnt, high_cnt, run_cnt, pub_val;

    pwm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset_n(reset_n),
        .d(pwm_in),
        .q(sample)
    );

    assign rise = enable & sample & ~prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else state <= state_nxt;
    end

    always_comb state_nxt = rise ? LOCKED : state;

    always_comb locked = (state == LOCKED);

    // A rise on the boundary tick is the expected frame start, not an error
    always_comb begin
        boundary = (state == LOCKED) && (tick_cnt == PER);
        run_done = (state == SEARCH) && (sample == prev) && (run_cnt == LAST_RUN);
        publish  = enable & (boundary | run_done);
        err      = rise & (state == LOCKED) & ~boundary;
        pub_val  = boundary ? high_cnt : (sample ? PER : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev       <= 1'b0;
            tick_cnt   <= '0;
            high_cnt   <= '0;
            run_cnt    <= '0;
            duty_cycle <= '0;
            valid      <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            valid    <= publish;
            sync_err <= err;
            if (publish) duty_cycle <= pub_val;
            if (enable) begin
                prev    <= sample;
                run_cnt <= (state == LOCKED || sample != prev || run_done) ? '0 : run_cnt + 1'b1;
                if (state == LOCKED || rise) begin
                    tick_cnt <= (boundary || rise) ? CNT_W'(1) : tick_cnt + 1'b1;
                    high_cnt <= boundary ? CNT_W'(sample) : rise ? CNT_W'(1) : high_cnt + CNT_W'(sample);
                end
            end
        end
    end
endmodule
